// File: rtl/pad_pkg.sv
// Shared encodings for the 2-D border padder: fill modes, FSM states and a
// counter-width helper.
package pad_pkg;

  typedef enum logic [1:0] {
    PAD_ZERO  = 2'd0,
    PAD_CONST = 2'd1,
    PAD_REPL  = 2'd2
  } pad_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StTop,
    StLeft,
    StBody,
    StRight,
    StBottom
  } pad_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_out_reg.sv
// Single-stage valid/ready output register carrying pixel data plus sof/eol.
// Loads whenever it is empty or being drained, so no bubble under steady m_ready.
module pad_out_reg #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  input  logic                  in_eol,
  output logic                  load,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol
);

  assign load = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (load) begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_data <= in_data;
        m_sof  <= in_sof;
        m_eol  <= in_eol;
      end
    end
  end

endmodule

// File: rtl/pad_frame.sv
// Streaming 2-D border padder: wraps each WIDTH x DEPTH frame with PAD_T/PAD_B rows
// and PAD_L/PAD_R columns using zero, constant or edge-replicate fill.
module pad_frame
  import pad_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WIDTH      = 634,
  parameter int unsigned DEPTH      = 506,
  parameter int unsigned PAD_L      = 3,
  parameter int unsigned PAD_R      = 3,
  parameter int unsigned PAD_T      = 1,
  parameter int unsigned PAD_B      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] pad_value,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  busy
);

  localparam int unsigned COLS = PAD_L + WIDTH + PAD_R;
  localparam int unsigned ROWS = PAD_T + DEPTH + PAD_B;
  localparam int unsigned CW   = cnt_width(COLS);
  localparam int unsigned RW   = cnt_width(ROWS);

  localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_LEFT_END = CW'(PAD_L - 1);
  localparam logic [CW-1:0] COL_BODY_END = CW'(PAD_L + WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_TOP_END  = RW'(PAD_T - 1);
  localparam logic [RW-1:0] ROW_BODY_END = RW'(PAD_T + DEPTH - 1);

  localparam pad_state_e ROW_START   = (PAD_L > 0) ? StLeft : StBody;
  localparam pad_state_e FRAME_START = (PAD_T > 0) ? StTop : ROW_START;

  pad_state_e            state_q, row_next;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] pad_q, last_pix_q;
  logic                  rdy_q, busy_q;
  logic                  emit, load, adv, repl;
  logic [DATA_WIDTH-1:0] fill, emit_data;

  always_comb begin
    repl      = (mode_q == PAD_REPL);
    fill      = (mode_q == PAD_CONST || repl) ? pad_q : '0;
    emit      = 1'b0;
    emit_data = fill;
    s_ready   = 1'b0;
    unique case (state_q)
      // The s_sof beat is only peeked here; it is consumed as the first body pixel.
      StIdle:          s_ready = rdy_q && !(s_valid && s_sof);
      StTop, StBottom: emit = 1'b1;
      StLeft: begin
        emit = s_valid;
        if (repl) emit_data = s_data;
      end
      StBody: begin
        emit      = s_valid;
        emit_data = s_data;
        s_ready   = load;
      end
      StRight: begin
        emit = 1'b1;
        if (repl) emit_data = last_pix_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    row_next = ROW_START;
    if (state_q == StTop && row_q != ROW_TOP_END) begin
      row_next = StTop;
    end else if (state_q == StBottom ||
                 ((state_q == StBody || state_q == StRight) && row_q == ROW_BODY_END)) begin
      row_next = StBottom;
    end
  end

  assign adv = emit && load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= PAD_ZERO;
      pad_q      <= '0;
      last_pix_q <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (state_q == StIdle) begin
        if (rdy_q && s_valid && s_sof) begin
          mode_q  <= mode;
          pad_q   <= pad_value;
          state_q <= FRAME_START;
          busy_q  <= 1'b1;
        end
      end else if (adv) begin
        if (state_q == StBody) last_pix_q <= s_data;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= row_next;
          end
        end else begin
          col_q <= col_q + 1'b1;
          if (state_q == StLeft && col_q == COL_LEFT_END) begin
            state_q <= StBody;
          end else if (state_q == StBody && col_q == COL_BODY_END) begin
            state_q <= StRight;
          end
        end
      end
    end
  end

  assign busy = busy_q;

  pad_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (emit),
    .in_data  (emit_data),
    .in_sof   ((row_q == '0) && (col_q == '0)),
    .in_eol   (col_q == COL_LAST),
    .load     (load),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_eol    (m_eol)
  );

endmodule

// File: doc/pad_frame.md
# pad_frame

Parametrised 2-D border padder for the edge-detection front end. Sits between the pixel source and the line-buffer/window generator. Adds PAD_T/PAD_B rows and PAD_L/PAD_R columns around each WIDTH x DEPTH frame using a valid/ready stream, with run-time selectable zero, constant or edge-replicate fill. This is the streaming, flow-controlled successor of the column-only padder.

## Interface
- DATA_WIDTH, 16: pixel width in bits
- WIDTH, 634: active pixels per input row
- DEPTH, 506: active rows per input frame
- PAD_L, 3: left pad columns (0..15)
- PAD_R, 3: right pad columns (0..15)
- PAD_T, 1: top pad rows (0..15)
- PAD_B, 1: bottom pad rows (0..15)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  fill mode: 0 zero, 1 constant, 2 replicate, 3 reserved (treated as 0)
- pad_value  in  DATA_WIDTH  constant fill value
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  input pixel
- s_sof  in  1  marks first pixel of a frame
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  padded pixel
- m_sof  out  1  first output pixel of the padded frame
- m_eol  out  1  last output pixel of each padded row
- busy  out  1  high from frame capture until the last bottom-pad pixel leaves

## Operation
- Output frame: (PAD_L+WIDTH+PAD_R) columns x (PAD_T+DEPTH+PAD_B) rows, raster order.
- mode and pad_value latched on the accepted s_sof beat; stable for the whole frame.
- FSM states: IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM. States with zero pad count are skipped.
- IDLE: s_ready=1; beats without s_sof are dropped. An s_sof beat is peeked, not consumed, and moves to TOP (or LEFT).
- TOP and BOTTOM rows: fill with 0 or pad_value. Replicate mode uses pad_value for these rows.
- LEFT: s_ready=0. Fill is 0, pad_value, or s_data in replicate mode. A pad beat is emitted only while s_valid=1, so the peeked first pixel of the row is used.
- BODY: passthrough. s_ready mirrors the output-register enable. Each accepted pixel is copied to last_pix.
- RIGHT: s_ready=0. Fill is 0, pad_value or last_pix.
- Counters: col_cnt is $clog2(PAD_L+WIDTH+PAD_R) bits and row_cnt is $clog2(PAD_T+DEPTH+PAD_B) bits. Both count emitted beats and wrap to 0 at end of row / end of frame.
- After the last BOTTOM beat, or after the last RIGHT beat when PAD_B=0, return to IDLE. busy falls the cycle after that beat is accepted.
- s_sof received while not in IDLE is ignored; the pixel is treated as ordinary data.

## Timing
- Output register is a single stage. It loads when !m_valid || m_ready, so there is no bubble under continuous m_ready.
- Latency: s_data to m_data is 1 cycle in BODY.
- With m_ready=1 and no input gaps, one output beat is produced per cycle.
- m_data, m_sof and m_eol are held while m_valid && !m_ready.
- m_sof is asserted on row 0, col 0 only. m_eol is asserted on col PAD_L+WIDTH+PAD_R-1 of every row.
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, busy=0, s_ready=0 during reset and 1 after reset (IDLE). FSM=IDLE, counters=0, last_pix=0.
- Reset mid-frame: the frame is abandoned and the block waits for the next s_sof.
- s_ready is combinational from FSM state and output enable. It has no combinational path from s_data.

## Structure
- Shared package pad_pkg: mode encodings (PAD_ZERO, PAD_CONST, PAD_REPL) and the FSM state enum.
- One sub-module, pad_out_reg: valid/ready output register carrying data, sof and eol.
- FSM, counters and fill mux live in pad_frame.

## Test plan
- WIDTH=4, DEPTH=2, all pads=1, mode=0, m_ready=1, input 1..8: 6x4 frame; row 0 all 0; row 1 is 0,1,2,3,4,0; m_sof on first beat; m_eol every 6th beat.
- Same sizes, mode=1, pad_value=0x0101: every border pixel is 0x0101 and interior pixels are unchanged.
- mode=2, PAD_T=PAD_B=0, PAD_L=PAD_R=2, row 5,6,7,9: output row is 5,5,5,6,7,9,9,9.
- Random m_ready (50%) and s_valid gaps: output sequence identical to the stall-free run; m_data stable while stalled; no beat lost or duplicated.
- Three beats without s_sof before the frame: all dropped, and output starts with m_sof. s_sof injected mid-frame is treated as data.
- rst_n pulled low mid-BODY, then a new frame sent: m_valid=0 during reset, and the new frame is output complete and correct.
